// File: rtl/temp_conv_pkg.sv
// Shared definitions for the temperature lookup controller and its ROM.
// Holds the controller state encoding and the Fahrenheit table function.
package temp_conv_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // round(9n/5 + 32), done in integers as (18n + 5) / 10 + 32
    function automatic int unsigned fahr_of(input int unsigned n);
        return (18 * n + 5) / 10 + 32;
    endfunction

endpackage

// File: rtl/temp_conv_rom.sv
// Synchronous ROM holding the Celsius-code to Fahrenheit table.
// Ports: clk, addr (DEPTH bits, sampled on rising edge), data (WIDTH bits, registered).
import temp_conv_pkg::*;

module temp_conv_rom #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic [DEPTH-1:0] addr,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        data_q <= WIDTH'(fahr_of(32'(addr)));
    end

    assign data = data_q;

endmodule

// File: rtl/temp_lookup_ctrl.sv
// Lookup controller in front of a synchronous ROM: single lookups or full sweeps.
// Ports: clk, rst (async high); req_valid/req_addr/req_ready request side;
// scan_start sweep trigger; rom_addr/rom_data ROM side; resp_valid/resp_addr/
// resp_data/resp_ready response side; busy and scan_done status.
import temp_conv_pkg::*;

module temp_lookup_ctrl #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [DEPTH-1:0] req_addr,
    output logic             req_ready,
    input  logic             scan_start,
    output logic [DEPTH-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic             resp_valid,
    output logic [DEPTH-1:0] resp_addr,
    output logic [WIDTH-1:0] resp_data,
    input  logic             resp_ready,
    output logic             busy,
    output logic             scan_done
);

    localparam logic [DEPTH-1:0] LAST_IDX = '1;
    localparam logic [DEPTH-1:0] ONE = {{(DEPTH-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic             scan_q, scan_d;
    logic [DEPTH-1:0] rom_addr_q, rom_addr_d;
    logic [DEPTH-1:0] resp_addr_q, resp_addr_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_valid_q, resp_valid_d;
    logic             scan_done_q, scan_done_d;

    always_comb begin
        state_d      = state_q;
        scan_d       = scan_q;
        rom_addr_d   = rom_addr_q;
        resp_addr_d  = resp_addr_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = resp_valid_q;
        scan_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (scan_start) begin
                    scan_d     = 1'b1;
                    rom_addr_d = '0;
                    state_d    = ST_WAIT;
                end else if (req_valid) begin
                    rom_addr_d = req_addr;
                    state_d    = ST_WAIT;
                end
            end
            // ROM samples rom_addr on this edge
            ST_WAIT: state_d = ST_CAPT;
            ST_CAPT: begin
                resp_data_d  = rom_data;
                resp_addr_d  = rom_addr_q;
                resp_valid_d = 1'b1;
                state_d      = ST_HOLD;
            end
            ST_HOLD: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    if (!scan_q) begin
                        state_d = ST_IDLE;
                    end else if (rom_addr_q != LAST_IDX) begin
                        rom_addr_d = rom_addr_q + ONE;
                        state_d    = ST_WAIT;
                    end else begin
                        scan_d      = 1'b0;
                        scan_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            scan_q       <= 1'b0;
            rom_addr_q   <= '0;
            resp_addr_q  <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            scan_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            scan_q       <= scan_d;
            rom_addr_q   <= rom_addr_d;
            resp_addr_q  <= resp_addr_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            scan_done_q  <= scan_done_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE) && !scan_start;
    assign busy       = (state_q != ST_IDLE);
    assign rom_addr   = rom_addr_q;
    assign resp_valid = resp_valid_q;
    assign resp_addr  = resp_addr_q;
    assign resp_data  = resp_data_q;
    assign scan_done  = scan_done_q;

endmodule

// File: tb/tb_temp_lookup_ctrl.sv
// Directed self-checking bench for temp_lookup_ctrl with a real Fahrenheit ROM.
// Each task drives one scenario and checks against hand-computed values.
module tb_temp_lookup_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_addr = 4'd0;
    logic       req_ready;
    logic       scan_start = 1'b0;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic       resp_valid;
    logic [3:0] resp_addr;
    logic [7:0] resp_data;
    logic       resp_ready = 1'b0;
    logic       busy;
    logic       scan_done;

    int total = 0;
    int bad = 0;
    logic [7:0] fahr [0:15];

    always #5 clk = ~clk;

    temp_lookup_ctrl #(.DEPTH(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .scan_start(scan_start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_data(resp_data),
        .resp_ready(resp_ready), .busy(busy), .scan_done(scan_done)
    );

    temp_conv_rom #(.DEPTH(4), .WIDTH(8)) rom (
        .clk(clk), .addr(rom_addr), .data(rom_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++;
        if ({resp_valid, resp_addr, resp_data, busy, scan_done, rom_addr} !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {resp_valid, resp_addr, resp_data, busy, scan_done, rom_addr});
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_req_ready got=%b want=1", req_ready);
        end
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_after_reset busy=%b ready=%b want 0/1", busy, req_ready);
        end
    endtask

    task automatic test_single();
        resp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr = 4'd5;
        tick();
        req_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || rom_addr !== 4'd5 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_accept busy=%b rom_addr=%0d rv=%b want 1/5/0",
                     busy, rom_addr, resp_valid);
        end
        tick();
        total++;
        if (resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early got=%b want=0", resp_valid);
        end
        tick();
        total++;
        if (resp_valid !== 1'b1 || resp_addr !== 4'd5 || resp_data !== 8'd41) begin
            bad++;
            $display("FAIL single_resp rv=%b addr=%0d data=%0d want 1/5/41",
                     resp_valid, resp_addr, resp_data);
        end
        tick();
        total++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_idle rv=%b busy=%b ready=%b want 0/0/1",
                     resp_valid, busy, req_ready);
        end
    endtask

    task automatic test_backpressure();
        int hs;
        resp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr = 4'd15;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        hs = 0;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (resp_valid !== 1'b1 || resp_data !== 8'd59 || busy !== 1'b1 || resp_addr !== 4'd15) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d rv=%b data=%0d busy=%b want 1/59/1",
                         i, resp_valid, resp_data, busy);
            end
            tick();
        end
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid === 1'b1) hs++;
            tick();
        end
        total++;
        if (hs !== 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_handshakes got=%0d busy=%b want 1/0", hs, busy);
        end
    endtask

    task automatic run_scan(input string tag, input bit poke_req);
        int cnt;
        int done;
        int cyc;
        cnt = 0;
        done = 0;
        cyc = 0;
        while (cyc < 200 && !(done > 0 && busy === 1'b0)) begin
            tick();
            cyc++;
            if (poke_req && cnt == 3) req_valid = 1'b1;
            if (poke_req && cnt == 6) req_valid = 1'b0;
            if (req_valid && busy) begin
                total++;
                if (req_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_midscan_ready got=%b want=0", tag, req_ready);
                end
            end
            if (scan_done === 1'b1) begin
                done++;
                total++;
                if (cnt != 16) begin
                    bad++;
                    $display("FAIL %s_done_early got=%0d want=16", tag, cnt);
                end
            end
            if (resp_valid === 1'b1) begin
                total++;
                if (cnt > 15 || resp_addr !== 4'(cnt) || resp_data !== fahr[cnt[3:0]]) begin
                    bad++;
                    $display("FAIL %s_entry idx=%0d addr=%0d data=%0d", tag, cnt, resp_addr, resp_data);
                end
                cnt++;
            end
        end
        req_valid = 1'b0;
        total++;
        if (cnt != 16 || done != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_totals resp=%0d done=%0d busy=%b want 16/1/0", tag, cnt, done, busy);
        end
    endtask

    task automatic test_scan();
        resp_ready = 1'b1;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        total++;
        if (busy !== 1'b1 || rom_addr !== 4'd0) begin
            bad++;
            $display("FAIL scan_start busy=%b rom_addr=%0d want 1/0", busy, rom_addr);
        end
        run_scan("scan", 1'b0);
    endtask

    task automatic test_collision();
        resp_ready = 1'b1;
        scan_start = 1'b1;
        req_valid = 1'b1;
        req_addr = 4'd9;
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL coll_ready got=%b want=0", req_ready);
        end
        tick();
        scan_start = 1'b0;
        req_valid = 1'b0;
        total++;
        if (rom_addr !== 4'd0) begin
            bad++;
            $display("FAIL coll_rom_addr got=%0d want=0", rom_addr);
        end
        run_scan("coll", 1'b1);
    endtask

    task automatic test_reset_midscan();
        int cyc;
        int dones;
        resp_ready = 1'b0;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        cyc = 0;
        while (cyc < 200 && !(resp_valid === 1'b1 && resp_addr === 4'd7)) begin
            resp_ready = resp_valid;
            tick();
            cyc++;
            if (resp_valid === 1'b1 && resp_addr === 4'd7) resp_ready = 1'b0;
        end
        total++;
        if (resp_valid !== 1'b1 || resp_addr !== 4'd7 || resp_data !== 8'd45) begin
            bad++;
            $display("FAIL rst_reach_idx7 rv=%b addr=%0d data=%0d want 1/7/45",
                     resp_valid, resp_addr, resp_data);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || scan_done !== 1'b0 || rom_addr !== 4'd0) begin
            bad++;
            $display("FAIL rst_midscan rv=%b busy=%b done=%b rom=%0d want 0/0/0/0",
                     resp_valid, busy, scan_done, rom_addr);
        end
        tick();
        rst = 1'b0;
        resp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr = 4'd0;
        tick();
        req_valid = 1'b0;
        dones = 0;
        for (int i = 0; i < 2; i++) begin
            if (scan_done === 1'b1) dones++;
            tick();
        end
        total++;
        if (resp_valid !== 1'b1 || resp_addr !== 4'd0 || resp_data !== 8'd32 || dones != 0) begin
            bad++;
            $display("FAIL rst_lookup0 rv=%b addr=%0d data=%0d dones=%0d want 1/0/32/0",
                     resp_valid, resp_addr, resp_data, dones);
        end
        tick();
        total++;
        if (busy !== 1'b0 || scan_done !== 1'b0) begin
            bad++;
            $display("FAIL rst_final busy=%b done=%b want 0/0", busy, scan_done);
        end
    endtask

    initial begin
        fahr[0] = 8'd32;  fahr[1] = 8'd34;  fahr[2] = 8'd36;  fahr[3] = 8'd37;
        fahr[4] = 8'd39;  fahr[5] = 8'd41;  fahr[6] = 8'd43;  fahr[7] = 8'd45;
        fahr[8] = 8'd46;  fahr[9] = 8'd48;  fahr[10] = 8'd50; fahr[11] = 8'd52;
        fahr[12] = 8'd54; fahr[13] = 8'd55; fahr[14] = 8'd57; fahr[15] = 8'd59;
        #1;
        test_reset();
        test_single();
        test_backpressure();
        test_scan();
        test_collision();
        test_reset_midscan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
